// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Registered execute stage for the 32-bit MIPS datapath. It decodes
// ALUOp/opcode/funct into a 4-bit operation code, computes the ALU result and
// registers it behind a valid/ready output, with a valid/ready input.
//
// Optional feature: define ALU_EXEC_MULDIV_EN to add an iterative shift-add
// multiplier (mult/multu), HI/LO registers and mfhi/mflo. While a multiply is
// in flight, issue is stalled and busy is high.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   issue handshake
//   alu_op/opcode/funct  control fields for decode
//   src_a, src_b, shamt  operands
//   out_valid, out_ready result handshake
//   result, alu_cnt      registered result and decoded operation code
//   zero, overflow       result == 0; signed overflow for add/addi/sub
//   busy                 multi-cycle operation in progress
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [SH_W-1:0]  shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_cnt,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000, OP_SUB  = 4'b0001, OP_AND  = 4'b0010, OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100, OP_NOR  = 4'b0101, OP_SLT  = 4'b0110, OP_SLTU = 4'b0111,
    OP_SRL  = 4'b1000, OP_SLL  = 4'b1001, OP_MUL  = 4'b1010, OP_MFHI = 4'b1011,
    OP_MFLO = 4'b1100
  } alu_cnt_t;

  alu_cnt_t         dec_cnt, cnt_q;
  logic             ovf_en, dec_mul, dec_signed;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf;
  logic             out_free, accept, mul_wr;
  logic [WIDTH-1:0] mul_lo;

  // Decode
  always_comb begin
    dec_cnt    = OP_ADD;
    ovf_en     = 1'b0;
    dec_mul    = 1'b0;
    dec_signed = 1'b0;
    case (alu_op)
      2'b00: begin
        case (funct)
          6'b100000: begin dec_cnt = OP_ADD; ovf_en = 1'b1; end
          6'b100001: dec_cnt = OP_ADD;
          6'b100010: begin dec_cnt = OP_SUB; ovf_en = 1'b1; end
          6'b100011: dec_cnt = OP_SUB;
          6'b100100: dec_cnt = OP_AND;
          6'b100101: dec_cnt = OP_OR;
          6'b100110: dec_cnt = OP_XOR;
          6'b100111: dec_cnt = OP_NOR;
          6'b101010: dec_cnt = OP_SLT;
          6'b101011: dec_cnt = OP_SLTU;
          6'b000010: dec_cnt = OP_SRL;
          6'b000000: dec_cnt = OP_SLL;
`ifdef ALU_EXEC_MULDIV_EN
          6'b011000: begin dec_mul = 1'b1; dec_signed = 1'b1; end
          6'b011001: dec_mul = 1'b1;
          6'b010000: dec_cnt = OP_MFHI;
          6'b010010: dec_cnt = OP_MFLO;
`endif
          default:   dec_cnt = OP_ADD;
        endcase
      end
      2'b01: begin
        case (opcode)
          6'b001000: begin dec_cnt = OP_ADD; ovf_en = 1'b1; end
          6'b001001: dec_cnt = OP_ADD;
          6'b001100: dec_cnt = OP_AND;
          6'b001101: dec_cnt = OP_OR;
          6'b001110: dec_cnt = OP_XOR;
          6'b001010: dec_cnt = OP_SLT;
          6'b001011: dec_cnt = OP_SLTU;
          default:   dec_cnt = OP_ADD;
        endcase
      end
      2'b10:   dec_cnt = OP_ADD;
      default: dec_cnt = (opcode == 6'b000100 || opcode == 6'b000101) ? OP_SUB : OP_ADD;
    endcase
  end

`ifdef ALU_EXEC_MULDIV_EN
  typedef enum logic [1:0] {IDLE, MUL, WAIT} state_t;

  state_t             state, state_next;
  logic [2*WIDTH-1:0] mcand, acc, step_acc, final_prod, prod_wr;
  logic [WIDTH-1:0]   mplier, hi, lo;
  logic [SH_W:0]      mcnt;
  logic               neg, last_step;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  assign step_acc   = acc + (mplier[0] ? mcand : '0);
  assign final_prod = neg ? -step_acc : step_acc;
  assign last_step  = (mcnt == (SH_W+1)'(1));
  // WAIT already holds the signed product in acc; MUL writes it on the fly.
  assign prod_wr    = (state == WAIT) ? acc : final_prod;
  assign mul_lo     = prod_wr[WIDTH-1:0];
  assign in_ready   = (state == IDLE) && out_free;
  assign busy       = (state != IDLE);

  always_comb begin
    state_next = state;
    mul_wr     = 1'b0;
    case (state)
      IDLE: if (accept && dec_mul) state_next = MUL;
      MUL: begin
        if (last_step) begin
          if (out_free) begin
            mul_wr     = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (out_free) begin
          mul_wr     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      mcnt   <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_next;
      if (accept && dec_mul) begin
        mcand  <= (2*WIDTH)'(mag(src_a, dec_signed));
        mplier <= mag(src_b, dec_signed);
        acc    <= '0;
        mcnt   <= (SH_W+1)'(WIDTH);
        neg    <= dec_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
      end else if (state == MUL) begin
        acc    <= last_step ? final_prod : step_acc;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        mcnt   <= mcnt - 1'b1;
      end
      if (mul_wr) {hi, lo} <= prod_wr;
    end
  end
`else
  assign in_ready = out_free;
  assign busy     = 1'b0;
  assign mul_wr   = 1'b0;
  assign mul_lo   = '0;
`endif

  assign out_free = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign sum      = src_a + src_b;
  assign diff     = src_a - src_b;

  always_comb begin
    alu_res = '0;
    case (dec_cnt)
      OP_SUB:  alu_res = diff;
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_NOR:  alu_res = ~(src_a | src_b);
      OP_SLT:  alu_res[0] = $signed(src_a) < $signed(src_b);
      OP_SLTU: alu_res[0] = src_a < src_b;
      OP_SRL:  alu_res = src_b >> shamt;
      OP_SLL:  alu_res = src_b << shamt;
`ifdef ALU_EXEC_MULDIV_EN
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
`endif
      default: alu_res = sum;
    endcase
  end

  always_comb begin
    alu_ovf = 1'b0;
    if (ovf_en) begin
      if (dec_cnt == OP_SUB)
        alu_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
      else
        alu_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      cnt_q     <= OP_ADD;
      overflow  <= 1'b0;
    end else if (accept && !dec_mul) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      cnt_q     <= dec_cnt;
      overflow  <= alu_ovf;
    end else if (mul_wr) begin
      out_valid <= 1'b1;
      result    <= mul_lo;
      cnt_q     <= OP_MUL;
      overflow  <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign alu_cnt = cnt_q;
  assign zero    = (result == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
// Self-checking bench for alu_exec_unit (WIDTH=32). Directed cases cover reset,
// overflow, back-to-back issue with output backpressure and decode defaults;
// a randomized loop compares against a behavioural model using 64-bit
// arithmetic. Multiply cases are compiled in when ALU_EXEC_MULDIV_EN is set.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  alu_op = '0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  alu_cnt;
  logic        zero;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .opcode(opcode), .funct(funct), .src_a(src_a),
    .src_b(src_b), .shamt(shamt), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .alu_cnt(alu_cnt), .zero(zero), .overflow(overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: operation chosen by name, computed with wide signed math.
  function automatic void model(input logic [1:0] op, input logic [5:0] opc, input logic [5:0] fn,
                                input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                                output logic [31:0] r, output logic [3:0] c, output logic o);
    string  k = "add";
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s;
    longint lim = 64'sd2147483648;
    bit     chk;
    case (op)
      2'd0: case (fn)
        6'd34, 6'd35: k = "sub";
        6'd36: k = "and";
        6'd37: k = "or";
        6'd38: k = "xor";
        6'd39: k = "nor";
        6'd42: k = "slt";
        6'd43: k = "sltu";
        6'd2:  k = "srl";
        6'd0:  k = "sll";
        default: k = "add";
      endcase
      2'd1: case (opc)
        6'd12: k = "and";
        6'd13: k = "or";
        6'd14: k = "xor";
        6'd10: k = "slt";
        6'd11: k = "sltu";
        default: k = "add";
      endcase
      2'd2: k = "add";
      default: k = (opc == 6'd4 || opc == 6'd5) ? "sub" : "add";
    endcase
    chk = (op == 2'd0 && (fn == 6'd32 || fn == 6'd34)) || (op == 2'd1 && opc == 6'd8);
    s = (k == "sub") ? sa - sb : sa + sb;
    o = chk && (s >= lim || s < -lim);
    r = 32'(s);
    c = 4'd0;
    case (k)
      "sub":  c = 4'd1;
      "and":  begin c = 4'd2; r = a & b; end
      "or":   begin c = 4'd3; r = a | b; end
      "xor":  begin c = 4'd4; r = a ^ b; end
      "nor":  begin c = 4'd5; r = ~(a | b); end
      "slt":  begin c = 4'd6; r = (sa < sb) ? 32'd1 : 32'd0; end
      "sltu": begin c = 4'd7; r = (a < b) ? 32'd1 : 32'd0; end
      "srl":  begin c = 4'd8; r = b >> sh; end
      "sll":  begin c = 4'd9; r = b << sh; end
      default: c = 4'd0;
    endcase
  endfunction

  task automatic drive(input logic [1:0] op, input logic [5:0] opc, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    @(negedge clk);
    alu_op = op; opcode = opc; funct = fn; src_a = a; src_b = b; shamt = sh;
    in_valid = 1'b1;
  endtask

  task automatic issue_chk(input string tag, input logic [1:0] op, input logic [5:0] opc,
                           input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, input logic [31:0] er, input logic [3:0] ec,
                           input logic eo);
    drive(op, opc, fn, a, b, sh);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".result"}, 64'(result), 64'(er));
    check({tag, ".cnt"}, 64'(alu_cnt), 64'(ec));
    check({tag, ".ovf"}, 64'(overflow), 64'(eo));
    check({tag, ".zero"}, 64'(zero), 64'(er == 32'd0));
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [5:0] opc,
                       input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    logic [31:0] r;
    logic [3:0]  c;
    logic        o;
    model(op, opc, fn, a, b, sh, r, c, o);
    issue_chk(tag, op, opc, fn, a, b, sh, r, c, o);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

`ifdef ALU_EXEC_MULDIV_EN
  task automatic run_mul(input string tag, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo);
    int n = 0;
    drive(2'd0, 6'd0, fn, a, b, 5'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, ".busy"}, 64'(busy), 64'd1);
    check({tag, ".in_ready"}, 64'(in_ready), 64'd0);
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".latency"}, 64'(n), 64'd32);
    check({tag, ".result"}, 64'(result), 64'(exp_lo));
    check({tag, ".cnt"}, 64'(alu_cnt), 64'd10);
    check({tag, ".busy_end"}, 64'(busy), 64'd0);
  endtask
`endif

  initial begin
    logic [5:0] fn_tab [0:13];
    fn_tab = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39,
               6'd42, 6'd43, 6'd2, 6'd0, 6'd24, 6'd16};

    #12;
    check("rst.result", 64'(result), 64'd0);
    check("rst.zero", 64'(zero), 64'd1);
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.cnt", 64'(alu_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue_chk("add_ovf", 2'd0, 6'd0, 6'd32, 32'h7FFFFFFF, 32'd1, 5'd0, 32'h80000000, 4'd0, 1'b1);
    issue_chk("addu", 2'd0, 6'd0, 6'd33, 32'h7FFFFFFF, 32'd1, 5'd0, 32'h80000000, 4'd0, 1'b0);

    // Back-to-back with backpressure on the second result.
    issue_chk("slt", 2'd0, 6'd0, 6'd42, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd1, 4'd6, 1'b0);
    issue_chk("sltu", 2'd0, 6'd0, 6'd43, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd0, 4'd7, 1'b0);
    drive(2'd0, 6'd0, 6'd0, 32'd0, 32'd1, 5'd31);
    out_ready = 1'b0;
    #1;
    check("bp.in_ready_low", 64'(in_ready), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("bp.hold_valid", 64'(out_valid), 64'd1);
      check("bp.hold_result", 64'(result), 64'd0);
      check("bp.hold_cnt", 64'(alu_cnt), 64'd7);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp.in_ready_high", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("sll.result", 64'(result), 64'h80000000);
    check("sll.cnt", 64'(alu_cnt), 64'd9);
    check("sll.valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    check("pop.valid", 64'(out_valid), 64'd0);
    check("pop.result_held", 64'(result), 64'h80000000);

    issue_chk("beq", 2'd3, 6'd4, 6'd0, 32'd5, 32'd5, 5'd0, 32'd0, 4'd1, 1'b0);
    issue_chk("i_default", 2'd1, 6'd63, 6'd0, 32'd3, 32'd4, 5'd0, 32'd7, 4'd0, 1'b0);
    issue_chk("sub_ovf", 2'd0, 6'd0, 6'd34, 32'h80000000, 32'd1, 5'd0, 32'h7FFFFFFF, 4'd1, 1'b1);
    issue_chk("addi_ovf", 2'd1, 6'd8, 6'd0, 32'h80000000, 32'hFFFFFFFF, 5'd0, 32'h7FFFFFFF, 4'd0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      logic [1:0] op = 2'($urandom_range(0, 3));
      logic [5:0] opc = ($urandom_range(0, 3) == 0) ? 6'($urandom) :
                        6'($urandom_range(8, 14));
      logic [5:0] fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) :
                       fn_tab[$urandom_range(0, 13)];
      if (op == 2'd2) opc = $urandom_range(0, 1) ? 6'd35 : 6'd43;
      if (op == 2'd3 && $urandom_range(0, 1)) opc = 6'd4;
`ifdef ALU_EXEC_MULDIV_EN
      if (fn == 6'd24 || fn == 6'd25 || fn == 6'd16 || fn == 6'd18) fn = 6'd32;
`endif
      do_op("rand", op, opc, fn, pick_val(), pick_val(), 5'($urandom));
    end

`ifdef ALU_EXEC_MULDIV_EN
    run_mul("mult", 6'd24, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB);
    issue_chk("mfhi1", 2'd0, 6'd0, 6'd16, 32'd0, 32'd0, 5'd0, 32'hFFFFFFFF, 4'd11, 1'b0);
    issue_chk("mflo1", 2'd0, 6'd0, 6'd18, 32'd0, 32'd0, 5'd0, 32'hFFFFFFEB, 4'd12, 1'b0);
    run_mul("multu", 6'd25, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE);
    issue_chk("mfhi2", 2'd0, 6'd0, 6'd16, 32'd0, 32'd0, 5'd0, 32'd1, 4'd11, 1'b0);

    drive(2'd0, 6'd0, 6'd24, 32'd123, 32'd456, 5'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.valid", 64'(out_valid), 64'd0);
    check("abort.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    issue_chk("abort.mflo", 2'd0, 6'd0, 6'd18, 32'd0, 32'd0, 5'd0, 32'd0, 4'd12, 1'b0);
    issue_chk("abort.mfhi", 2'd0, 6'd0, 6'd16, 32'd0, 32'd0, 5'd0, 32'd0, 4'd11, 1'b0);
`else
    issue_chk("mult_as_add", 2'd0, 6'd0, 6'd24, 32'd5, 32'd6, 5'd0, 32'd11, 4'd0, 1'b0);
    check("nomul.busy", 64'(busy), 64'd0);
    issue_chk("mfhi_as_add", 2'd0, 6'd0, 6'd16, 32'd1, 32'd2, 5'd0, 32'd3, 4'd0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised, registered execute unit for the 32-bit MIPS datapath. It folds the ALUOp/Opcode/Funct control decode and the ALU datapath into one block with valid/ready handshakes on both sides. It adds an optional iterative multiplier with HI/LO registers. It sits between the ID/EX pipeline register and the EX/MEM stage, and stalls issue while a multi-cycle operation is in flight.

## Interface
- WIDTH, 32, datapath width; power of two, ≥ 8
- SH_W, $clog2(WIDTH), shift-amount width (derived; do not override)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low; one clock, asynchronous active-low reset, no other clocks
- in_valid  in  1  issue request
- in_ready  out  1  unit can accept this cycle
- alu_op  in  2  00 R-type, 01 I-type ALU, 10 load/store, 11 branch
- opcode  in  6  instruction opcode
- funct  in  6  R-type function field
- src_a  in  WIDTH  rs operand
- src_b  in  WIDTH  rt or pre-extended immediate
- shamt  in  SH_W  shift amount
- out_valid  out  1  result register holds valid data
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  registered result
- alu_cnt  out  4  registered decoded operation code
- zero  out  1  result == 0
- overflow  out  1  signed overflow for add/addi/sub only
- busy  out  1  multi-cycle operation in progress

## Operation
- Accept on in_valid && in_ready.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- Decode, alu_cnt:
  - alu_op 00, funct: 100000/100001 add 0000; 100010/100011 sub 0001; 100100 and 0010; 100101 or 0011; 100110 xor 0100; 100111 nor 0101; 101010 slt 0110; 101011 sltu 0111; 000010 srl 1000; 000000 sll 1001.
  - alu_op 01, opcode: 001000/001001 add; 001100 and; 001101 or; 001110 xor; 001010 slt; 001011 sltu.
  - alu_op 10, opcodes 100011/101011: add.
  - alu_op 11, opcodes 000100/000101: sub.
  - Any other combination: 0000 (add).
- Arithmetic:
  - add/sub are modulo 2^WIDTH.
  - overflow is set only for funct 100000/100010 and opcode 001000 (alu_op 01), using the signed rule; 0 for all other ops.
  - slt/sltu give 1 or 0, zero-extended.
  - srl: src_b >> shamt, logical. sll: src_b << shamt.
- Single-cycle ops: result, alu_cnt, zero, overflow and out_valid=1 are loaded on the accept edge.
- Output register holds while out_valid && !out_ready.
- out_valid clears on the pop edge, unless a new accept occurs on the same edge.
- FSM, IDLE / MUL / WAIT, present only with the macro:
  - IDLE -> MUL on accept of a multiply; operands are latched and the counter loads WIDTH.
  - MUL: one shift-add step per cycle; counter decrements.
  - MUL -> IDLE at counter 1 if !out_valid || out_ready; HI/LO are written and the output is loaded with result=LO, alu_cnt=1010.
  - Otherwise MUL -> WAIT. WAIT -> IDLE on the first cycle with !out_valid || out_ready, performing the same writes.
  - busy = (state != IDLE).
- Signed mult: magnitudes are multiplied, then the 2·WIDTH product is negated if the operand signs differ.
- Reset: out_valid=0, result=0, alu_cnt=0000, zero=1 (from result=0), overflow=0, busy=0, state=IDLE, HI=LO=0.
- Reset asserted mid-multiply aborts the operation; HI/LO return to 0.

## Timing
- Single-cycle op: accept at edge T -> out_valid from T, throughput 1/cycle with out_ready=1.
- Multiply: accept at T -> out_valid at T+WIDTH (32 edges for WIDTH=32), provided the output is free.
- in_ready falls combinationally when out_valid && !out_ready.
- in_ready is low throughout MUL and WAIT.
- mfhi/mflo issued right after a mult always see the new HI/LO, because issue is blocked until mult completes.

## Configuration
- ALU_EXEC_MULDIV_EN defined:
  - R-type funct 011000 mult (signed) and 011001 multu (unsigned) use the FSM.
  - 010000 mfhi gives result=HI, alu_cnt=1011; 010010 mflo gives result=LO, alu_cnt=1100. Both are single-cycle.
- Undefined:
  - These functs decode to the default 0000 (add), single-cycle.
  - No HI/LO registers and no FSM; busy is tied to 0.

## Test plan
- Reset, then check outputs: result=0, zero=1, out_valid=0, in_ready=1, busy=0.
- alu_op 00 funct 100000, src_a=0x7FFFFFFF, src_b=1, out_ready=1 -> next edge: result=0x80000000, overflow=1, alu_cnt=0000. Same operands with funct 100001 -> overflow=0.
- Back-to-back issue of slt(−1,1) then sltu(−1,1) then sll (src_b=1, shamt=31) -> results 1, 0, 0x80000000 on consecutive edges. Hold out_ready=0 on the second result -> it is held and in_ready=0 until released.
- alu_op 11 opcode 000100, src_a=src_b=5 -> result=0, zero=1, alu_cnt=0001. alu_op 01 opcode 111111 -> alu_cnt=0000.
- With macro: mult src_a=−3, src_b=7 -> busy for 32 cycles, then result=LO=0xFFFFFFEB. mfhi -> 0xFFFFFFFF. multu 0xFFFFFFFF×2 -> HI=1, LO=0xFFFFFFFE.
- With macro: assert rst_n low at cycle 10 of a mult -> busy=0, state IDLE, no out_valid; a subsequent mflo returns 0.
